// File: rtl/line_clear_engine_if.sv
// line_clear_engine_if: start/result bundle between the lock logic and line_clear_engine
// Signals:
//   start         - single-cycle run request (master -> slave)
//   board_in      - locked board, [col][row], row 0 = top (master -> slave)
//   board_out     - board after clearing, held until next completion (slave -> master)
//   busy, done    - run in progress / one-cycle completion pulse (slave -> master)
//   lines_cleared - rows removed by the last run (slave -> master)
//   cleared_mask  - original row indices that were full (slave -> master)
//   total_lines   - saturating cumulative line count, only with LINE_CLEAR_STATS_EN
interface line_clear_engine_if;
    logic             start;
    logic [9:0][19:0] board_in;
    logic [9:0][19:0] board_out;
    logic             busy;
    logic             done;
    logic [4:0]       lines_cleared;
    logic [19:0]      cleared_mask;
`ifdef LINE_CLEAR_STATS_EN
    logic [15:0]      total_lines;
    modport master (output start, board_in,
                    input  board_out, busy, done, lines_cleared, cleared_mask, total_lines);
    modport slave  (input  start, board_in,
                    output board_out, busy, done, lines_cleared, cleared_mask, total_lines);
`else
    modport master (output start, board_in,
                    input  board_out, busy, done, lines_cleared, cleared_mask);
    modport slave  (input  start, board_in,
                    output board_out, busy, done, lines_cleared, cleared_mask);
`endif
endinterface

// File: rtl/line_clear_engine.sv
// line_clear_engine: sequential full-row detection and collapse of the locked Tetris board
// Ports:
//   clk   - game clock, rising edge
//   reset - synchronous active-high reset
//   bus   - line_clear_engine_if.slave (start, board_in, board_out, busy, done,
//           lines_cleared, cleared_mask, total_lines when enabled)
// Optional feature: define LINE_CLEAR_STATS_EN to add the saturating total_lines counter.
package game_state_pkg;
    typedef struct packed {
        logic [9:0][19:0] screen;
    } game_state_t;
endpackage

module line_clear_engine
    import game_state_pkg::*;
(
    input logic          clk,
    input logic          reset,
    line_clear_engine_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t      r_state;
    game_state_t r_work;
    game_state_t r_board_out;
    logic [4:0]  r_row;
    logic [4:0]  r_k;
    logic [19:0] r_m;
    logic [4:0]  r_lines;
    logic [19:0] r_mask;
    logic        r_busy;
    logic        r_done;

    logic        w_full;
    game_state_t w_shift;
    logic [4:0]  w_idx;

    // Row r_row is full when every column has it set; the shifted board drops rows 0..r_row-1 down by one.
    always_comb begin
        w_full  = 1'b1;
        w_shift = r_work;
        for (int c = 0; c < 10; c++) begin
            w_full = w_full & r_work.screen[c][r_row];
            w_shift.screen[c][0] = 1'b0;
            for (int i = 1; i < 20; i++)
                if (5'(i) <= r_row) w_shift.screen[c][i] = r_work.screen[c][i-1];
        end
    end

    // After k shifts the row at r_row originally sat at r_row - k.
    assign w_idx = r_row - r_k;

`ifdef LINE_CLEAR_STATS_EN
    logic [15:0] r_total;
    logic [16:0] w_sum;
    assign w_sum           = {1'b0, r_total} + {12'b0, r_k};
    assign bus.total_lines = r_total;

    always_ff @(posedge clk)
        if (reset) r_total <= '0;
        else if (r_state == SCAN && !w_full && r_row == 5'd0) r_total <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_work      <= '0;
            r_board_out <= '0;
            r_row       <= '0;
            r_k         <= '0;
            r_m         <= '0;
            r_lines     <= '0;
            r_mask      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_work  <= bus.board_in;
                    r_row   <= 5'd19;
                    r_k     <= '0;
                    r_m     <= '0;
                    r_busy  <= 1'b1;
                    r_state <= SCAN;
                end
                SCAN: if (w_full) begin
                    // Row index held so the row that dropped into it is checked next.
                    r_work     <= w_shift;
                    r_k        <= r_k + 5'd1;
                    r_m[w_idx] <= 1'b1;
                end else if (r_row != 5'd0) begin
                    r_row <= r_row - 5'd1;
                end else begin
                    r_board_out <= r_work;
                    r_lines     <= r_k;
                    r_mask      <= r_m;
                    r_done      <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.board_out     = r_board_out;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.lines_cleared = r_lines;
    assign bus.cleared_mask  = r_mask;
endmodule

// File: tb/tb_line_clear_engine.sv
// tb_line_clear_engine: self-checking bench for line_clear_engine against a row-filtering reference model
module tb_line_clear_engine;
    import game_state_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   tot   = 0;

    line_clear_engine_if bus();

    line_clear_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: keep non-full rows in bottom-up order, restack them from row 19, pad empty rows on top.
    task automatic model(input game_state_t b, output game_state_t o, output int k, output logic [19:0] m);
        logic [9:0] q[$];
        logic [9:0] row;
        k = 0;
        m = '0;
        o = '0;
        for (int r = 19; r >= 0; r--) begin
            for (int c = 0; c < 10; c++) row[c] = b.screen[c][r];
            if (&row) begin
                m[r] = 1'b1;
                k++;
            end else q.push_back(row);
        end
        for (int j = 0; j < q.size(); j++)
            for (int c = 0; c < 10; c++) o.screen[c][19-j] = q[j][c];
    endtask

    task automatic run(input game_state_t b, input string tag);
        game_state_t eo;
        game_state_t prev;
        int          ek;
        int          n;
        logic [19:0] em;
        model(b, eo, ek, em);
        prev = bus.board_out;
        @(negedge clk);
        bus.board_in = b;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk({tag, " busy_rise"}, bus.busy, 1);
        chk({tag, " out_hold"}, bus.board_out, prev);
        n = 0;
        while (!bus.done && n < 100) begin
            @(posedge clk);
            #1 n++;
            // A start during SCAN with a different board must be ignored.
            bus.start    = (n == 3);
            bus.board_in = (n == 3) ? ~b : b;
        end
        bus.start = 1'b0;
        tot = (tot + ek > 65535) ? 65535 : tot + ek;
        chk({tag, " latency"}, n, 20 + ek);
        chk({tag, " board"}, bus.board_out, eo);
        chk({tag, " lines"}, bus.lines_cleared, ek);
        chk({tag, " mask"}, bus.cleared_mask, em);
`ifdef LINE_CLEAR_STATS_EN
        chk({tag, " total"}, bus.total_lines, tot);
`endif
        @(posedge clk);
        #1 chk({tag, " done_fall"}, {bus.done, bus.busy}, 0);
        @(posedge clk);
        #1 chk({tag, " no_queue"}, bus.busy, 0);
    endtask

    function automatic game_state_t rnd_board();
        game_state_t b;
        logic [9:0]  row;
        for (int r = 0; r < 20; r++) begin
            row = ($urandom_range(2) == 0) ? 10'h3FF : 10'($urandom);
            for (int c = 0; c < 10; c++) b.screen[c][r] = row[c];
        end
        return b;
    endfunction

    function automatic game_state_t clear_n(input int n);
        game_state_t b = '0;
        for (int r = 20 - n; r < 20; r++)
            for (int c = 0; c < 10; c++) b.screen[c][r] = 1'b1;
        b.screen[5][19-n] = 1'b1;
        return b;
    endfunction

    initial begin
        game_state_t b;
        int          seen;
        bus.start    = 1'b0;
        bus.board_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy", bus.busy, 0);
        chk("rst done", bus.done, 0);
        chk("rst board", bus.board_out, 0);
        chk("rst lines", bus.lines_cleared, 0);
        chk("rst mask", bus.cleared_mask, 0);
        reset = 1'b0;

        run('0, "empty");

        b = '0;
        for (int c = 0; c < 10; c++) b.screen[c][19] = 1'b1;
        b.screen[3][18] = 1'b1;
        run(b, "row19");

        b = '0;
        for (int c = 0; c < 10; c++) begin
            b.screen[c][19] = 1'b1;
            b.screen[c][17] = 1'b1;
        end
        b.screen[0][18] = 1'b1;
        b.screen[9][16] = 1'b1;
        run(b, "rows17_19");

        b = '1;
        run(b, "full");

        b = '0;
        b.screen[0][0] = 1'b1;
        for (int c = 0; c < 10; c++) b.screen[c][0] = 1'b1;
        run(b, "row0");

        // Reset landing on E5 of a run, after a start pulse during SCAN.
        @(negedge clk);
        bus.board_in = '1;
        bus.start    = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        tot = 0;
        chk("midrst busy", bus.busy, 0);
        chk("midrst done", bus.done, 0);
        chk("midrst board", bus.board_out, 0);
        chk("midrst lines", bus.lines_cleared, 0);
        chk("midrst mask", bus.cleared_mask, 0);
`ifdef LINE_CLEAR_STATS_EN
        chk("midrst total", bus.total_lines, 0);
`endif
        seen = 0;
        repeat (45) begin
            @(posedge clk);
            #1 seen += (bus.done | bus.busy);
        end
        chk("midrst quiet", seen, 0);

        run(clear_n(1), "stats1");
        run(clear_n(4), "stats4");
        run(clear_n(2), "stats2");
`ifdef LINE_CLEAR_STATS_EN
        chk("stats sum7", bus.total_lines, 7);
`endif

        for (int t = 0; t < 8; t++) run(rnd_board(), $sformatf("rand%0d", t));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
